fetch_sequencer: RTL and testbench

- Multi-cycle fetch controller for the Y86-64 core. Owns the architectural PC register.
- Issues one 10-byte instruction-memory request per instruction and splits the returned bytes into icode/ifun/rA/rB/valC.
- Computes valP and hands the instruction to decode over a valid/ready handshake.
- Handles control-flow redirects (pc_load), halt, invalid-instruction and memory-error stops.

---
 rtl/fetch_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch controller: owns the PC, issues one 10-byte imem request per
// instruction, decodes the returned bytes and offers them to decode over valid/ready.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [63:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [79:0]      imem_data,
    input  logic             imem_err,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [3:0]       f_icode,
    output logic [3:0]       f_ifun,
    output logic [3:0]       f_rA,
    output logic [3:0]       f_rB,
    output logic [63:0]      f_valC,
    output logic [63:0]      f_valP,
    output logic [63:0]      f_pc,
    output logic [2:0]       f_stat,
    input  logic             pc_load,
    input  logic [63:0]      pc_new,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, STOP} state_t;

    state_t      state, next_state;
    logic [63:0] pc, pc_next;
    logic        squash, squash_next;
    logic [63:0] target, target_next;
    logic        capture, count;

    // Combinational decode of the bytes currently on imem_data.
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic        need_regids, need_valc, ifun_bad;
    logic [63:0] d_valC, d_valP;
    logic [2:0]  d_stat;

    always_comb begin
        d_icode     = imem_data[7:4];
        d_ifun      = imem_data[3:0];
        need_regids = (d_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        need_valc   = (d_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        d_rA        = need_regids ? imem_data[15:12] : 4'hF;
        d_rB        = need_regids ? imem_data[11:8]  : 4'hF;
        if (!need_valc)
            d_valC = 64'h0;
        else if (need_regids)
            d_valC = imem_data[79:16];
        else
            d_valC = imem_data[71:8];
        d_valP = pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        case (d_icode)
            4'h2, 4'h7: ifun_bad = (d_ifun > 4'd6);
            4'h6:       ifun_bad = (d_ifun > 4'd3);
            default:    ifun_bad = (d_ifun != 4'd0);
        endcase
        if (imem_err)
            d_stat = STAT_ADR;
        else if (d_icode > 4'hB || ifun_bad)
            d_stat = STAT_INS;
        else if (d_icode == 4'h0)
            d_stat = STAT_HLT;
        else
            d_stat = STAT_AOK;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pc_next     = pc;
        squash_next = squash;
        target_next = target;
        capture     = 1'b0;
        count       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    // A redirect seen now or earlier in this request discards the data.
                    if (squash || pc_load) begin
                        pc_next     = pc_load ? pc_new : target;
                        squash_next = 1'b0;
                    end else begin
                        capture    = 1'b1;
                        next_state = HOLD;
                    end
                end else if (pc_load) begin
                    target_next = pc_new;
                    squash_next = 1'b1;
                end
            end
            HOLD: begin
                if (f_ready) begin
                    count = 1'b1;
                    if (f_stat != STAT_AOK) begin
                        next_state = STOP;
                    end else begin
                        pc_next    = pc_load ? pc_new : f_valP;
                        next_state = REQ;
                    end
                end else if (pc_load) begin
                    pc_next    = pc_new;
                    next_state = REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            squash    <= 1'b0;
            target    <= 64'h0;
            f_icode   <= 4'h0;
            f_ifun    <= 4'h0;
            f_rA      <= 4'h0;
            f_rB      <= 4'h0;
            f_valC    <= 64'h0;
            f_valP    <= 64'h0;
            f_pc      <= 64'h0;
            f_stat    <= STAT_AOK;
            instr_cnt <= '0;
        end else begin
            pc     <= pc_next;
            squash <= squash_next;
            target <= target_next;
            if (capture) begin
                f_icode <= d_icode;
                f_ifun  <= d_ifun;
                f_rA    <= d_rA;
                f_rB    <= d_rB;
                f_valC  <= d_valC;
                f_valP  <= d_valP;
                f_pc    <= pc;
                f_stat  <= d_stat;
            end
            if (count)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Handshake: a transfer occurs on a rising edge where f_valid and f_ready are both high;
    // f_* stay stable while f_valid is high and f_ready is low.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign f_valid   = (state == HOLD);
    assign busy      = (state == REQ) || (state == HOLD);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed vectors checked with immediate assertions.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [79:0] imem_data = 80'h0;
    logic        imem_err = 1'b0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP, f_pc;
    logic [2:0]  f_stat;
    logic        pc_load = 1'b0;
    logic [63:0] pc_new = 64'h0;
    logic        busy;
    logic [31:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .imem_err(imem_err),
        .f_valid(f_valid), .f_ready(f_ready),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_pc(f_pc), .f_stat(f_stat),
        .pc_load(pc_load), .pc_new(pc_new), .busy(busy), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Acknowledge the outstanding request in the current cycle with the given bytes.
    task automatic feed(input string tag, input logic [79:0] d, input logic e);
        chk({tag, "_req"}, {63'd0, imem_req}, 64'd1);
        imem_ack  = 1'b1;
        imem_data = d;
        imem_err  = e;
        step();
        imem_ack  = 1'b0;
        imem_err  = 1'b0;
    endtask

    initial begin
        // Reset state and irmovq decode
        do_reset();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'd0, f_valid}, 64'd0);
        chk("rst_stat", {61'd0, f_stat}, 64'd1);
        chk("rst_cnt", {32'd0, instr_cnt}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        do_start();
        chk("t1_addr", imem_addr, 64'h0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        feed("t1", 80'h0000000000000123F330, 1'b0);
        chk("t1_valid", {63'd0, f_valid}, 64'd1);
        chk("t1_icode", {60'd0, f_icode}, 64'h3);
        chk("t1_ifun", {60'd0, f_ifun}, 64'h0);
        chk("t1_rA", {60'd0, f_rA}, 64'hF);
        chk("t1_rB", {60'd0, f_rB}, 64'h3);
        chk("t1_valC", f_valC, 64'h123);
        chk("t1_valP", f_valP, 64'h0A);
        chk("t1_stat", {61'd0, f_stat}, 64'd1);
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        chk("t1_next_addr", imem_addr, 64'h0A);
        chk("t1_cnt", {32'd0, instr_cnt}, 64'd1);

        // nop / OPq with stall / halt
        do_reset();
        do_start();
        feed("t2a", 80'h10, 1'b0);
        chk("t2a_valP", f_valP, 64'h1);
        chk("t2a_rA", {60'd0, f_rA}, 64'hF);
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        chk("t2b_addr", imem_addr, 64'h1);
        feed("t2b", 80'h1260, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2b_stall_valid", {63'd0, f_valid}, 64'd1);
            chk("t2b_stall_icode", {60'd0, f_icode}, 64'h6);
            chk("t2b_stall_rA", {60'd0, f_rA}, 64'h1);
            chk("t2b_stall_rB", {60'd0, f_rB}, 64'h2);
            chk("t2b_stall_valP", f_valP, 64'h3);
            chk("t2b_stall_pc", f_pc, 64'h1);
            step();
        end
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        chk("t2c_addr", imem_addr, 64'h3);
        feed("t2c", 80'h00, 1'b0);
        chk("t2c_valP", f_valP, 64'h4);
        chk("t2c_stat", {61'd0, f_stat}, 64'd2);
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        chk("t2_stop_req", {63'd0, imem_req}, 64'd0);
        chk("t2_stop_valid", {63'd0, f_valid}, 64'd0);
        chk("t2_stop_cnt", {32'd0, instr_cnt}, 64'd3);
        chk("t2_stop_stat", {61'd0, f_stat}, 64'd2);
        pc_load = 1'b1;
        pc_new  = 64'h80;
        start   = 1'b1;
        step();
        pc_load = 1'b0;
        start   = 1'b0;
        step();
        chk("t2_stop_ignore_req", {63'd0, imem_req}, 64'd0);
        chk("t2_stop_ignore_busy", {63'd0, busy}, 64'd0);

        // Delayed ack with a redirect while waiting
        do_reset();
        do_start();
        step();
        pc_load = 1'b1;
        pc_new  = 64'h40;
        step();
        pc_load = 1'b0;
        chk("t3_wait_addr", imem_addr, 64'h0);
        step();
        step();
        chk("t3_wait_addr2", imem_addr, 64'h0);
        chk("t3_wait_valid", {63'd0, f_valid}, 64'd0);
        feed("t3_squash", 80'h10, 1'b0);
        chk("t3_squash_valid", {63'd0, f_valid}, 64'd0);
        chk("t3_squash_req", {63'd0, imem_req}, 64'd1);
        chk("t3_redirect_addr", imem_addr, 64'h40);
        feed("t3b", 80'h10, 1'b0);
        chk("t3b_valid", {63'd0, f_valid}, 64'd1);
        chk("t3b_pc", f_pc, 64'h40);
        chk("t3b_valP", f_valP, 64'h41);

        // jXX transfer with same-cycle redirect
        do_reset();
        do_start();
        feed("t4", {8'h00, 64'h200, 8'h70}, 1'b0);
        chk("t4_valC", f_valC, 64'h200);
        chk("t4_valP", f_valP, 64'h9);
        chk("t4_rB", {60'd0, f_rB}, 64'hF);
        f_ready = 1'b1;
        pc_load = 1'b1;
        pc_new  = 64'h100;
        step();
        f_ready = 1'b0;
        pc_load = 1'b0;
        chk("t4_redirect_addr", imem_addr, 64'h100);
        chk("t4_cnt", {32'd0, instr_cnt}, 64'd1);

        // Invalid function code, then address error over invalid icode
        do_reset();
        do_start();
        feed("t5a", 80'h67, 1'b0);
        chk("t5a_stat", {61'd0, f_stat}, 64'd4);
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        chk("t5a_stop_valid", {63'd0, f_valid}, 64'd0);
        chk("t5a_stop_req", {63'd0, imem_req}, 64'd0);
        chk("t5a_stop_stat", {61'd0, f_stat}, 64'd4);
        do_reset();
        do_start();
        feed("t5b", 80'hC0, 1'b1);
        chk("t5b_stat", {61'd0, f_stat}, 64'd3);

        // PC wrap-around, then reset in the middle of a request
        do_reset();
        do_start();
        pc_load = 1'b1;
        pc_new  = 64'hFFFF_FFFF_FFFF_FFFC;
        feed("t6_redirect", 80'h0, 1'b0);
        pc_load = 1'b0;
        chk("t6_redirect_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_redirect_valid", {63'd0, f_valid}, 64'd0);
        feed("t6", 80'h0000000000000123F330, 1'b0);
        chk("t6_pc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_valP", f_valP, 64'h6);
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        chk("t6_wrap_addr", imem_addr, 64'h6);
        chk("t6_in_req", {63'd0, imem_req}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_req", {63'd0, imem_req}, 64'd0);
        chk("t6_rst_addr", imem_addr, 64'h0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_valid", {63'd0, f_valid}, 64'd0);
        chk("t6_rst_stat", {61'd0, f_stat}, 64'd1);
        chk("t6_rst_cnt", {32'd0, instr_cnt}, 64'd0);
        chk("t6_rst_icode", {60'd0, f_icode}, 64'd0);
        chk("t6_rst_valP", f_valP, 64'd0);
        chk("t6_rst_pc", f_pc, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
